// File: rtl/scoreboard_hazard.sv
// Issue-stage register scoreboard: tracks pending vector/scalar write-backs and
// stalls decode on RAW/WAW hazards against entries that are not retiring this cycle.
module scoreboard_hazard #(
   parameter int WB_LAT = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        issue_valid,
   input  logic [2:0]  vsrc1,
   input  logic [2:0]  vsrc2,
   input  logic        vsrc1_use,
   input  logic        vsrc2_use,
   input  logic [2:0]  ssrc,
   input  logic        ssrc_use,
   input  logic [2:0]  dir_dest,
   input  logic        reg_wrv,
   input  logic        reg_wrs,
   output logic        stall,
   output logic        bubble,
   output logic [7:0]  busy_v,
   output logic [7:0]  busy_s,
   output logic [15:0] stall_cnt
);

   localparam logic [1:0] LAT = 2'(WB_LAT);

   logic [1:0]  cnt_v [8];
   logic [1:0]  cnt_s [8];
   logic [7:0]  blk_v;
   logic [7:0]  blk_s;
   logic [15:0] stall_cnt_q;
   logic        accept;

   // An entry with cnt==1 writes back this cycle, so it no longer blocks.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         blk_v[i] = busy_v[i] && (cnt_v[i] > 2'd1);
         blk_s[i] = busy_s[i] && (cnt_s[i] > 2'd1);
      end
   end

   assign stall = issue_valid &&
                  ((vsrc1_use && blk_v[vsrc1]) ||
                   (vsrc2_use && blk_v[vsrc2]) ||
                   (ssrc_use  && blk_s[ssrc])  ||
                   (reg_wrv   && blk_v[dir_dest]) ||
                   (reg_wrs   && blk_s[dir_dest]));

   assign bubble    = stall;
   assign accept    = issue_valid && !stall;
   assign stall_cnt = stall_cnt_q;

   // Allocation takes priority over retirement of the same entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_v      <= '0;
         busy_s      <= '0;
         stall_cnt_q <= '0;
         for (int i = 0; i < 8; i++) begin
            cnt_v[i] <= '0;
            cnt_s[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (accept && reg_wrv && (dir_dest == 3'(i))) begin
               busy_v[i] <= 1'b1;
               cnt_v[i]  <= LAT;
            end else if (busy_v[i]) begin
               if (cnt_v[i] == 2'd1) begin
                  busy_v[i] <= 1'b0;
                  cnt_v[i]  <= 2'd0;
               end else begin
                  cnt_v[i] <= cnt_v[i] - 2'd1;
               end
            end

            if (accept && reg_wrs && (dir_dest == 3'(i))) begin
               busy_s[i] <= 1'b1;
               cnt_s[i]  <= LAT;
            end else if (busy_s[i]) begin
               if (cnt_s[i] == 2'd1) begin
                  busy_s[i] <= 1'b0;
                  cnt_s[i]  <= 2'd0;
               end else begin
                  cnt_s[i] <= cnt_s[i] - 2'd1;
               end
            end
         end

         if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_scoreboard_hazard.sv
// Directed bench for scoreboard_hazard: WB_LAT=3 main instance plus a WB_LAT=1
// instance sharing the same stimulus.
module tb_scoreboard_hazard;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        issue_valid;
   logic [2:0]  vsrc1, vsrc2, ssrc, dir_dest;
   logic        vsrc1_use, vsrc2_use, ssrc_use, reg_wrv, reg_wrs;

   logic        stall, bubble, stall1, bubble1;
   logic [7:0]  busy_v, busy_s, busy_v1, busy_s1;
   logic [15:0] stall_cnt, stall_cnt1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   scoreboard_hazard #(.WB_LAT(3)) dut (
      .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid),
      .vsrc1(vsrc1), .vsrc2(vsrc2), .vsrc1_use(vsrc1_use), .vsrc2_use(vsrc2_use),
      .ssrc(ssrc), .ssrc_use(ssrc_use), .dir_dest(dir_dest),
      .reg_wrv(reg_wrv), .reg_wrs(reg_wrs),
      .stall(stall), .bubble(bubble), .busy_v(busy_v), .busy_s(busy_s),
      .stall_cnt(stall_cnt)
   );

   scoreboard_hazard #(.WB_LAT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid),
      .vsrc1(vsrc1), .vsrc2(vsrc2), .vsrc1_use(vsrc1_use), .vsrc2_use(vsrc2_use),
      .ssrc(ssrc), .ssrc_use(ssrc_use), .dir_dest(dir_dest),
      .reg_wrv(reg_wrv), .reg_wrs(reg_wrs),
      .stall(stall1), .bubble(bubble1), .busy_v(busy_v1), .busy_s(busy_s1),
      .stall_cnt(stall_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 0; vsrc1 = 0; vsrc2 = 0; ssrc = 0; dir_dest = 0;
      vsrc1_use = 0; vsrc2_use = 0; ssrc_use = 0; reg_wrv = 0; reg_wrs = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset_n = 0;
      #2;
      chk("rst_busy_v", 32'(busy_v), 32'h00);
      chk("rst_busy_s", 32'(busy_s), 32'h00);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_bubble", 32'(bubble), 32'h0);
      @(negedge clk);
      reset_n = 1;
      tick();

      // RAW on vector reg 2
      issue_valid = 1; dir_dest = 2; reg_wrv = 1;
      #1 chk("raw_c0_stall", 32'(stall), 32'h0);
      tick();
      chk("raw_c1_busy_v", 32'(busy_v), 32'h04);
      chk("lat1_c1_busy_v", 32'(busy_v1), 32'h04);
      reg_wrv = 0; dir_dest = 0; vsrc1 = 2; vsrc1_use = 1;
      issue_valid = 0;
      #1 chk("raw_novalid_stall", 32'(stall), 32'h0);
      issue_valid = 1;
      #1 chk("raw_c1_stall", 32'(stall), 32'h1);
      chk("raw_c1_bubble", 32'(bubble), 32'h1);
      chk("lat1_c1_stall", 32'(stall1), 32'h0);
      tick();
      chk("raw_c2_stall", 32'(stall), 32'h1);
      chk("lat1_c2_busy_v", 32'(busy_v1), 32'h00);
      tick();
      chk("raw_c3_stall", 32'(stall), 32'h0);
      chk("raw_c3_stall_cnt", 32'(stall_cnt), 32'h2);
      tick();
      idle();
      chk("raw_done_busy_v", 32'(busy_v), 32'h00);
      chk("lat1_stall_cnt", 32'(stall_cnt1), 32'h0);

      // Independent issue
      issue_valid = 1; dir_dest = 1; reg_wrv = 1;
      #1 chk("ind_c0_stall", 32'(stall), 32'h0);
      tick();
      reg_wrv = 0; dir_dest = 0; vsrc1 = 4; vsrc1_use = 1; vsrc2 = 5; vsrc2_use = 1;
      #1 chk("ind_c1_stall", 32'(stall), 32'h0);
      chk("ind_busy_v_1", 32'(busy_v), 32'h02);
      tick();
      idle();
      chk("ind_busy_v_2", 32'(busy_v), 32'h02);
      tick();
      chk("ind_busy_v_3", 32'(busy_v), 32'h02);
      tick();
      chk("ind_busy_v_0", 32'(busy_v), 32'h00);

      // WAW on scalar reg 3; re-allocation lands on the retiring edge
      issue_valid = 1; dir_dest = 3; reg_wrs = 1;
      tick();
      #1 chk("waw_c1_stall", 32'(stall), 32'h1);
      chk("lat1_waw_stall", 32'(stall1), 32'h0);
      tick();
      chk("waw_c2_stall", 32'(stall), 32'h1);
      tick();
      chk("waw_c3_stall", 32'(stall), 32'h0);
      chk("waw_c3_busy_s", 32'(busy_s), 32'h08);
      tick();
      idle();
      chk("waw_c4_busy_s", 32'(busy_s), 32'h08);
      tick();
      chk("waw_c5_busy_s", 32'(busy_s), 32'h08);
      tick();
      chk("waw_c6_busy_s", 32'(busy_s), 32'h08);
      tick();
      chk("waw_c7_busy_s", 32'(busy_s), 32'h00);
      chk("waw_stall_cnt", 32'(stall_cnt), 32'h4);

      // Vector and scalar writes in one issue
      issue_valid = 1; dir_dest = 5; reg_wrv = 1; reg_wrs = 1;
      tick();
      idle();
      chk("both_busy_v", 32'(busy_v), 32'h20);
      chk("both_busy_s", 32'(busy_s), 32'h20);
      tick(); tick(); tick();
      chk("both_clear_v", 32'(busy_v), 32'h00);

      // Vector write to 6 does not block a scalar read of 6
      issue_valid = 1; dir_dest = 6; reg_wrv = 1;
      tick();
      reg_wrv = 0; dir_dest = 0; ssrc = 6; ssrc_use = 1;
      #1 chk("sep_ssrc_stall", 32'(stall), 32'h0);
      vsrc2 = 6; vsrc2_use = 1;
      #1 chk("sep_vsrc2_stall", 32'(stall), 32'h1);
      vsrc2_use = 0;
      #1 chk("sep_ssrc_stall2", 32'(stall), 32'h0);
      tick();
      idle();
      tick(); tick();
      chk("sep_stall_cnt", 32'(stall_cnt), 32'h4);

      // Saturation: counter preloaded near the top to keep the run short
      force dut.stall_cnt_q = 16'hFFFC;
      #1 release dut.stall_cnt_q;
      issue_valid = 1; dir_dest = 0; reg_wrv = 1;
      tick();
      reg_wrv = 0; vsrc1 = 0; vsrc1_use = 1;
      tick(); tick();
      chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
      reg_wrv = 1;
      tick();
      reg_wrv = 0;
      tick();
      chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
      tick();
      chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
      idle();
      tick();

      // Asynchronous reset mid-cycle
      issue_valid = 1; dir_dest = 0; reg_wrv = 1;
      tick();
      dir_dest = 7;
      tick();
      idle();
      chk("arst_pre_busy_v", 32'(busy_v), 32'h81);
      #2 reset_n = 0;
      #1 chk("arst_busy_v", 32'(busy_v), 32'h00);
      chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
      @(negedge clk);
      reset_n = 1;
      issue_valid = 1; vsrc1 = 7; vsrc1_use = 1; dir_dest = 0; reg_wrv = 1;
      #1 chk("arst_post_stall", 32'(stall), 32'h0);
      tick();
      idle();
      chk("arst_post_busy_v", 32'(busy_v), 32'h01);
      chk("arst_post_cnt", 32'(stall_cnt), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
